// File: rtl/ucsie_rx_adapter_if.sv
// Bundle of the adapter's handshake channels:
//   phy_rx_*  : beats arriving from the PHY receive path
//   rx_*      : FWFT head beat offered to the protocol layer
//   crd_ret_* : credit returns toward the link partner's transmitter
//   err_proto : sticky framing error
// slave  = adapter side, master = environment side (PHY, protocol layer, credit sink).
interface ucsie_rx_adapter_if #(
  parameter int DATA_W   = 256,
  parameter int CREDIT_W = 8
);
  logic                  phy_rx_valid;
  logic                  phy_rx_ready;
  logic [DATA_W-1:0]     phy_rx_data;
  logic [DATA_W/8-1:0]   phy_rx_strb;
  logic                  phy_rx_sop;
  logic                  phy_rx_eop;

  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_W-1:0]     rx_data;
  logic [DATA_W/8-1:0]   rx_strb;
  logic                  rx_sop;
  logic                  rx_eop;

  logic                  crd_ret_valid;
  logic                  crd_ret_ready;
  logic [CREDIT_W-1:0]   crd_ret_cnt;

  logic                  err_proto;

  modport slave (
    input  phy_rx_valid, phy_rx_data, phy_rx_strb, phy_rx_sop, phy_rx_eop,
    output phy_rx_ready,
    output rx_valid, rx_data, rx_strb, rx_sop, rx_eop,
    input  rx_ready,
    output crd_ret_valid, crd_ret_cnt,
    input  crd_ret_ready,
    output err_proto
  );

  modport master (
    output phy_rx_valid, phy_rx_data, phy_rx_strb, phy_rx_sop, phy_rx_eop,
    input  phy_rx_ready,
    input  rx_valid, rx_data, rx_strb, rx_sop, rx_eop,
    output rx_ready,
    input  crd_ret_valid, crd_ret_cnt,
    output crd_ret_ready,
    input  err_proto
  );
endinterface

// File: rtl/ucsie_rx_adapter.sv
// UCIe receive-side adapter: SOP/EOP framing check, FWFT beat FIFO toward
// the protocol layer, and per-beat credit return to the link partner.
// Optional feature macro: UCSIE_RX_CRD_COALESCE_EN
//   defined   -> credits are returned once CRD_THRESH have accumulated, or
//                after CRD_TIMEOUT idle cycles with a partial count.
//   undefined -> a return is issued whenever any credit is pending.
module ucsie_rx_adapter #(
  parameter int DATA_W      = 256,
  parameter int FIFO_DEPTH  = 16,
  parameter int CREDIT_W    = 8,
  parameter int CRD_THRESH  = 8,
  parameter int CRD_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  ucsie_rx_adapter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = DATA_W + STRB_W + 2;

  // Elaboration-time parameter sanity checks.
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 128) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..128");
  end
  if (FIFO_DEPTH >= (1 << CREDIT_W)) begin : g_bad_credit_w
    $error("CREDIT_W too narrow to hold FIFO_DEPTH");
  end
  if ((CRD_THRESH < 1) || (CRD_THRESH > FIFO_DEPTH)) begin : g_bad_thresh
    $error("CRD_THRESH must be in 1..FIFO_DEPTH");
  end
  if ((CRD_TIMEOUT < 1) || (CRD_TIMEOUT > 255)) begin : g_bad_timeout
    $error("CRD_TIMEOUT must be in 1..255");
  end

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t              r_state;
  logic                r_err_proto;
  logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [CREDIT_W-1:0] r_pending;
  logic [CREDIT_W-1:0] r_crd_cnt;
  logic                r_crd_valid;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_write;
  logic                w_pop;
  logic                w_crd_hs;
  logic                w_trigger;
  logic [CREDIT_W-1:0] w_pop_inc;
  logic [ENT_W-1:0]    w_head;

  // Extra wrap bit on each pointer separates full from empty.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_accept  = bus.phy_rx_valid && !w_full;
  // A beat without SOP outside a packet is dropped rather than stored.
  assign w_write   = w_accept && (bus.phy_rx_sop || (r_state == IN_PKT));
  assign w_pop     = !w_empty && bus.rx_ready;
  assign w_crd_hs  = r_crd_valid && bus.crd_ret_ready;
  assign w_pop_inc = CREDIT_W'(w_pop);

  // Ingress framing FSM with the sticky protocol error as a registered output.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_err_proto <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (bus.phy_rx_sop) r_state <= bus.phy_rx_eop ? IDLE : IN_PKT;
          else                r_err_proto <= 1'b1;
        end
        IN_PKT: begin
          if (bus.phy_rx_sop) r_err_proto <= 1'b1;
          r_state <= bus.phy_rx_eop ? IDLE : IN_PKT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat storage.
  // NOTE: the array is deliberately not reset; pointers define validity and the
  // egress mux forces zeros while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.phy_rx_data, bus.phy_rx_strb, bus.phy_rx_sop, bus.phy_rx_eop};
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // First-word-fall-through head; zeros when nothing is buffered.
  assign w_head           = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.phy_rx_ready = !w_full;
  assign bus.rx_valid     = !w_empty;
  assign {bus.rx_data, bus.rx_strb, bus.rx_sop, bus.rx_eop} = w_empty ? '0 : w_head;

`ifdef UCSIE_RX_CRD_COALESCE_EN
  logic [7:0] r_idle_tmr;

  // Idle timer: counts cycles with credits waiting, no pop and no return in flight.
  always_ff @(posedge clk) begin
    if (rst || w_pop || w_crd_hs) begin
      r_idle_tmr <= '0;
    end else if ((r_pending != '0) && !r_crd_valid && (r_idle_tmr != 8'hFF)) begin
      r_idle_tmr <= r_idle_tmr + 8'd1;
    end
  end

  assign w_trigger = (r_pending >= CREDIT_W'(CRD_THRESH)) ||
                     ((r_idle_tmr >= 8'(CRD_TIMEOUT)) && (r_pending != '0));
`else
  assign w_trigger = (r_pending != '0);
`endif

  // Credit accounting and return channel; the reset value is the initial grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= CREDIT_W'(FIFO_DEPTH);
      r_crd_valid <= 1'b0;
      r_crd_cnt   <= '0;
    end else if (w_crd_hs) begin
      r_pending   <= r_pending - r_crd_cnt + w_pop_inc;
      r_crd_valid <= 1'b0;
    end else begin
      if (!r_crd_valid && w_trigger) begin
        r_crd_valid <= 1'b1;
        r_crd_cnt   <= r_pending;
      end
      r_pending <= r_pending + w_pop_inc;
    end
  end

  assign bus.crd_ret_valid = r_crd_valid;
  assign bus.crd_ret_cnt   = r_crd_cnt;
  assign bus.err_proto     = r_err_proto;

endmodule
